seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 8-digit common-anode 7-segment display. It holds eight 4-bit digit values, cycles through digits 0..7, and drives one active-low digit enable at a time with the matching active-low segment pattern. A blanking dead-time between digits suppresses ghosting. Writes go to a shadow buffer and are applied atomically at a frame boundary, so the display never tears.

---
 rtl/seg_scan_ctrl.sv | 169 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment
// display. Eight 4-bit digit values (plus a blank flag) are written into a
// shadow buffer and copied atomically into the active buffer at the start of
// a frame after a commit request, so a frame never mixes old and new data.
// Each digit slot is DEAD_CYC dark cycles followed by SHOW_CYC lit cycles.
//
// Parameters:
//   SHOW_CYC   clock cycles each digit is lit (>=1)
//   DEAD_CYC   blank cycles before each digit is lit (>=1)
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active-high
//   en          scan enable; 0 = dark, scan held at start
//   wr_en       shadow buffer write strobe
//   wr_addr     digit index to write (0..7)
//   wr_data     bit4 = blank flag, bits3:0 = digit value
//   commit      request shadow->active copy at next frame start
//   seg         segments g..a (bit6=g), active-low, registered
//   dig         digit enables, active-low, registered, one-hot-low or all high
//   frame_done  one-cycle pulse on the first dark cycle after digit 7
module seg_scan_ctrl #(
  parameter int SHOW_CYC = 50000,
  parameter int DEAD_CYC = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic       commit,
  output logic [6:0] seg,
  output logic [7:0] dig,
  output logic       frame_done
);

  localparam int MAX_CYC = (SHOW_CYC > DEAD_CYC) ? SHOW_CYC : DEAD_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYC - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);

  typedef enum logic {
    DEAD = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t        state;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  logic [4:0]    shadow [8];
  logic [4:0]    active [8];
  logic          pending;

  logic       dead_end;
  logic       show_end;
  logic       latch;
  logic [4:0] lit_val;

  // Active-low segment decode; A-F and the blank flag both go dark.
  function automatic logic [6:0] decode(input logic [4:0] v);
    logic [6:0] s;
    s = 7'h7F;
    if (!v[4]) begin
      case (v[3:0])
        4'd0: s = 7'b1000000;
        4'd1: s = 7'b1111001;
        4'd2: s = 7'b0100100;
        4'd3: s = 7'b0110000;
        4'd4: s = 7'b0011001;
        4'd5: s = 7'b0010010;
        4'd6: s = 7'b0000010;
        4'd7: s = 7'b1111000;
        4'd8: s = 7'b0000000;
        4'd9: s = 7'b0010000;
        default: s = 7'h7F;
      endcase
    end
    return s;
  endfunction

  // The copy happens on the edge that lights digit 0. The segment register
  // is loaded on that same edge, so it must see the value being copied in
  // rather than the stale active entry.
  always_comb begin
    dead_end = (state == DEAD) && (cnt == DEAD_LAST);
    show_end = (state == SHOW) && (cnt == SHOW_LAST);
    latch    = en && dead_end && (idx == 3'd0) && pending;
    lit_val  = latch ? shadow[0] : active[idx];
  end

  // Buffers and commit flag keep working while the scan is disabled. The
  // copy reads shadow before this edge's write lands, and a commit on the
  // latch edge wins over the clear so the copy repeats next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= 5'h10;
        active[i] <= 5'h10;
      end
      pending <= 1'b0;
    end else begin
      if (wr_en) begin
        shadow[wr_addr] <= wr_data;
      end
      if (latch) begin
        for (int i = 0; i < 8; i++) begin
          active[i] <= shadow[i];
        end
      end
      if (commit) begin
        pending <= 1'b1;
      end else if (latch) begin
        pending <= 1'b0;
      end
    end
  end

  // Scan FSM with registered outputs that change on the state-change edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= DEAD;
      idx        <= 3'd0;
      cnt        <= '0;
      seg        <= 7'h7F;
      dig        <= 8'hFF;
      frame_done <= 1'b0;
    end else if (!en) begin
      state      <= DEAD;
      idx        <= 3'd0;
      cnt        <= '0;
      seg        <= 7'h7F;
      dig        <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        DEAD: begin
          if (dead_end) begin
            state <= SHOW;
            cnt   <= '0;
            dig   <= ~(8'd1 << idx);
            seg   <= decode(lit_val);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW: begin
          if (show_end) begin
            state      <= DEAD;
            idx        <= idx + 3'd1;
            cnt        <= '0;
            dig        <= 8'hFF;
            seg        <= 7'h7F;
            frame_done <= (idx == 3'd7);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= DEAD;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
// Scoreboard bench for seg_scan_ctrl with SHOW_CYC=4, DEAD_CYC=2. A position
// model (cycle count since scan start, folded into frame/slot/phase) predicts
// {dig, seg, frame_done} for every cycle; predictions are queued at the clock
// edge and compared against the DUT on the following falling edge.
module tb_seg_scan_ctrl;

  localparam int SHOW = 4;
  localparam int DEAD = 2;
  localparam int SLOT = SHOW + DEAD;
  localparam int FR   = 8 * SLOT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [4:0] wr_data = 5'd0;
  logic       commit = 1'b0;
  logic [6:0] seg;
  logic [7:0] dig;
  logic       frame_done;

  int compared = 0;
  int mismatched = 0;

  int          t = 0;
  logic [4:0]  msh [8];
  logic [4:0]  mac [8];
  logic        mpend = 1'b0;
  logic [15:0] mcur = {8'hFF, 7'h7F, 1'b0};
  logic [15:0] q [$];

  seg_scan_ctrl #(.SHOW_CYC(SHOW), .DEAD_CYC(DEAD)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .commit(commit),
    .seg(seg),
    .dig(dig),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts, and reports any difference.
  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got dig=%h seg=%b fd=%b, expected dig=%h seg=%b fd=%b",
               tag, got[15:8], got[7:1], got[0], exp[15:8], exp[7:1], exp[0]);
    end
  endtask

  // Drives one cycle of inputs at the falling edge and waits for the next one.
  task automatic applyStimulus(input logic we, input logic [2:0] a, input logic [4:0] d,
                               input logic cm, input logic e);
    wr_en   = we;
    wr_addr = a;
    wr_data = d;
    commit  = cm;
    en      = e;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd0, 5'd0, 1'b0, 1'b1);
  endtask

  // Idles until the model sits at the given frame position, bounded.
  task automatic alignTo(input int pos);
    int n;
    n = 0;
    while ((t % FR) != pos && n < 2 * FR) begin
      idle(1);
      n++;
    end
    if ((t % FR) != pos) checkOutput("align", 16'(t % FR), 16'(pos));
  endtask

  // Reference decode from a lookup table.
  function automatic logic [6:0] refSeg(input logic [4:0] v);
    logic [6:0] tab [10];
    tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (v[4] || v[3:0] > 4'd9) return 7'h7F;
    return tab[v[3:0]];
  endfunction

  // Expected outputs for scan position tt, from frame/slot arithmetic.
  function automatic logic [15:0] expOut(input int tt);
    int pos, d, w;
    logic [7:0] ed;
    logic [6:0] es;
    pos = tt % FR;
    d   = pos / SLOT;
    w   = pos % SLOT;
    ed  = 8'hFF;
    es  = 7'h7F;
    if (w >= DEAD) begin
      ed = ~(8'd1 << d);
      es = refSeg(mac[d]);
    end
    return {ed, es, (tt >= FR && pos == 0)};
  endfunction

  // Model step on each edge; pushes the prediction for the coming cycle.
  always @(posedge clk or posedge rst) begin
    int tn;
    if (rst) begin
      t = 0;
      mpend = 1'b0;
      for (int i = 0; i < 8; i++) begin
        msh[i] = 5'h10;
        mac[i] = 5'h10;
      end
      mcur = {8'hFF, 7'h7F, 1'b0};
      q.delete();
    end else begin
      tn = en ? t + 1 : 0;
      if (en && (tn % FR) == DEAD && mpend) begin
        for (int i = 0; i < 8; i++) mac[i] = msh[i];
        mpend = 1'b0;
      end
      if (commit) mpend = 1'b1;
      if (wr_en) msh[wr_addr] = wr_data;
      t = tn;
      mcur = expOut(t);
      q.push_back(mcur);
    end
  end

  // Scoreboard pop on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [15:0] e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checkOutput($sformatf("scan t=%0d", t), {dig, seg, frame_done}, e);
    end
  end

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", {dig, seg, frame_done}, {8'hFF, 7'h7F, 1'b0});
    rst = 1'b0;

    // Blank display for two frames, frame_done cadence.
    idle(2 * FR + 4);

    // Digits 0..7 = 1..8, then commit.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(i), 5'(i + 1), 1'b0, 1'b1);
    applyStimulus(1'b0, 3'd0, 5'd0, 1'b1, 1'b1);
    idle(2 * FR);

    // Blank flag on digit 3, hex C on digit 4.
    applyStimulus(1'b1, 3'd3, 5'h19, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'd4, 5'h0C, 1'b1, 1'b1);
    idle(2 * FR);

    // Writes without commit leave the display unchanged.
    applyStimulus(1'b1, 3'd0, 5'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'd1, 5'd9, 1'b0, 1'b1);
    idle(3 * FR);

    // Write and commit on the latch edge, with an earlier commit pending.
    applyStimulus(1'b1, 3'd1, 5'd3, 1'b1, 1'b1);
    alignTo(DEAD - 1);
    applyStimulus(1'b1, 3'd0, 5'd7, 1'b1, 1'b1);
    idle(2 * FR + 3);

    // Drop en mid-SHOW of digit 5.
    alignTo(5 * SLOT + DEAD + 1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
    idle(FR + 10);

    // Async reset mid-SHOW.
    alignTo(2 * SLOT + DEAD + 1);
    #2 rst = 1'b1;
    #1 checkOutput("async_rst", {dig, seg, frame_done}, {8'hFF, 7'h7F, 1'b0});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(FR + 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
